// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes and flag bit positions for the LEGv8 execute path.
// Imported by the ALU control decoder and by the execute stage.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational LEGv8 ALU: computes result and {N,Z,C,V} for one control code.
// Unsupported codes (including X/Z) yield zero result, zero flags and illegal=1.
module alu_core
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [3:0]       code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

    always_comb begin
        result  = '0;
        flags   = '0;
        illegal = 1'b0;
        case (code)
            ALU_AND:   result = a & b;
            ALU_ORR:   result = a | b;
            ALU_PASSB: result = b;
            ALU_ADD: begin
                result        = w_sum[WIDTH-1:0];
                flags[FLAG_C] = w_sum[WIDTH];
                flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) &&
                                (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result        = w_diff[WIDTH-1:0];
                flags[FLAG_C] = w_diff[WIDTH];
                flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) &&
                                (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            default:   illegal = 1'b1;
        endcase
        // N/Z follow the result for every legal code; illegal codes keep all flags clear
        if (!illegal) begin
            flags[FLAG_N] = result[WIDTH-1];
            flags[FLAG_Z] = (result == '0);
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: alu_core behind a one-entry ready/valid output register,
// with an accepted-operation counter and a sticky illegal-code flag.
module alu_exec_stage
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_In,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal_op,
    output logic             err_sticky,
    output logic [15:0]      op_count
);

    logic [WIDTH-1:0] w_result;
    logic [3:0]       w_flags;
    logic             w_illegal;
    logic             w_accept;

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic [TAG_W-1:0] r_tag;
    logic             r_illegal;
    logic             r_err;
    logic [15:0]      r_count;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .code    (ALU_In),
        .a       (op_a),
        .b       (op_b),
        .result  (w_result),
        .flags   (w_flags),
        .illegal (w_illegal)
    );

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Accept wins over drain, so a simultaneous accept+drain keeps r_valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_result  <= '0;
            r_flags   <= '0;
            r_tag     <= '0;
            r_illegal <= 1'b0;
            r_err     <= 1'b0;
            r_count   <= '0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_result  <= w_result;
            r_flags   <= w_flags;
            r_tag     <= in_tag;
            r_illegal <= w_illegal;
            r_err     <= r_err | w_illegal;
            r_count   <= r_count + 16'd1;
        end else if (out_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign result     = r_result;
    assign flags      = r_flags;
    assign out_tag    = r_tag;
    assign illegal_op = r_illegal;
    assign err_sticky = r_err;
    assign op_count   = r_count;

endmodule
